// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
// Provides default widths, the zero-register index and a popcount helper.
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int ZERO_REG   = 0;

    // Widest busy vector popcount accepts; narrower vectors are zero-extended.
    localparam int MAX_REGS   = 1024;

    function automatic int unsigned popcount(input logic [MAX_REGS-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < MAX_REGS; i++) begin
            n = n + 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/regfile_busy_tracker.sv
// Per-register pending-write scoreboard with registered busy count.
// Ports: Clk, Reset (async high), RW/RegWr clear, RD/Reserve set,
//        Flush clear-all, busy_o vector, count_o popcount of busy_o.
module regfile_busy_tracker
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [ADDR_W-1:0]        RW,
    input  logic                     RegWr,
    input  logic [ADDR_W-1:0]        RD,
    input  logic                     Reserve,
    input  logic                     Flush,
    output logic [(2**ADDR_W)-1:0]   busy_o,
    output logic [ADDR_W:0]          count_o
);

    localparam int DEPTH = 2**ADDR_W;
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);

    logic [DEPTH-1:0] busy_d, busy_q;
    logic [CNT_W-1:0] count_d, count_q;

    // Priority: Flush > Reserve > RegWr clear. A same-edge Reserve
    // beats the write because the newer producer is still outstanding.
    always_comb begin
        busy_d = busy_q;
        if (RegWr && (RW != ZERO_A)) begin
            busy_d[RW] = 1'b0;
        end
        if (Flush) begin
            busy_d = '0;
        end else if (Reserve && (RD != ZERO_A)) begin
            busy_d[RD] = 1'b1;
        end
        busy_d[ZERO_REG] = 1'b0;
        count_d = CNT_W'(popcount(MAX_REGS'(busy_d)));
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    assign busy_o  = busy_q;
    assign count_o = count_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Two-read / one-write register file with pending-write scoreboard.
// Ports: Clk, Reset (async high); RA/RB -> BusA/BusB, ValidA/ValidB;
//        RW/BusW/RegWr write; RD/Reserve -> DestBusy; Flush; BusyCount.
// Optional: define REGFILE_BYPASS_EN for same-cycle write-to-read bypass.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int                DATA_W    = DEF_DATA_W,
    parameter int                ADDR_W    = DEF_ADDR_W,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] RA,
    input  logic [ADDR_W-1:0] RB,
    output logic [DATA_W-1:0] BusA,
    output logic [DATA_W-1:0] BusB,
    output logic              ValidA,
    output logic              ValidB,
    input  logic [ADDR_W-1:0] RW,
    input  logic [DATA_W-1:0] BusW,
    input  logic              RegWr,
    input  logic [ADDR_W-1:0] RD,
    input  logic              Reserve,
    output logic              DestBusy,
    input  logic              Flush,
    output logic [ADDR_W:0]   BusyCount
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic              wr_en;

    assign wr_en = RegWr && (RW != ZERO_A);

    regfile_busy_tracker #(
        .ADDR_W (ADDR_W)
    ) u_busy (
        .Clk     (Clk),
        .Reset   (Reset),
        .RW      (RW),
        .RegWr   (RegWr),
        .RD      (RD),
        .Reserve (Reserve),
        .Flush   (Flush),
        .busy_o  (busy),
        .count_o (BusyCount)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= RESET_VAL;
            end
        end else if (wr_en) begin
            regs_q[RW] <= BusW;
        end
    end

    always_comb begin
        BusA   = (RA == ZERO_A) ? '0 : regs_q[RA];
        BusB   = (RB == ZERO_A) ? '0 : regs_q[RB];
        ValidA = ~busy[RA];
        ValidB = ~busy[RB];
`ifdef REGFILE_BYPASS_EN
        // Writeback data forwarded so decode can share the cycle.
        if (wr_en && (RA == RW)) begin
            BusA   = BusW;
            ValidA = 1'b1;
        end
        if (wr_en && (RB == RW)) begin
            BusB   = BusW;
            ValidB = 1'b1;
        end
`endif
    end

    assign DestBusy = busy[RD];

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed table,
// hand-written reset/bypass sequences and randomized model checks.
module tb_regfile_scoreboard;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [4:0]  RA, RB, RW, RD;
    logic [31:0] BusA, BusB, BusW;
    logic        ValidA, ValidB, RegWr, Reserve, Flush, DestBusy;
    logic [5:0]  BusyCount;

    int checks = 0;
    int errors = 0;

    regfile_scoreboard dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .RA        (RA),
        .RB        (RB),
        .BusA      (BusA),
        .BusB      (BusB),
        .ValidA    (ValidA),
        .ValidB    (ValidB),
        .RW        (RW),
        .BusW      (BusW),
        .RegWr     (RegWr),
        .RD        (RD),
        .Reserve   (Reserve),
        .DestBusy  (DestBusy),
        .Flush     (Flush),
        .BusyCount (BusyCount)
    );

    always #5 Clk = ~Clk;

    // Reference model: plain arrays updated by the architectural rules.
    logic [31:0] mregs [32];
    bit          mbusy [32];

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) begin
            mregs[i] = 32'h0;
            mbusy[i] = 1'b0;
        end
    endfunction

    function automatic void model_edge();
        if (RegWr && RW != 0) begin
            mregs[RW] = BusW;
            mbusy[RW] = 1'b0;
        end
        if (Flush) begin
            for (int i = 0; i < 32; i++) mbusy[i] = 1'b0;
        end else if (Reserve && RD != 0) begin
            mbusy[RD] = 1'b1;
        end
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (a == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (RegWr && RW != 0 && RW == a) return BusW;
`endif
        return mregs[a];
    endfunction

    function automatic logic exp_valid(input logic [4:0] a);
        if (a == 0) return 1'b1;
`ifdef REGFILE_BYPASS_EN
        if (RegWr && RW != 0 && RW == a) return 1'b1;
`endif
        return !mbusy[a];
    endfunction

    function automatic logic [31:0] exp_count();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(mbusy[i]);
        return 32'(n);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] ra, input logic [4:0] rb,
                         input logic [4:0] rw, input logic [31:0] busw,
                         input logic regwr, input logic [4:0] rd,
                         input logic reserve, input logic flush);
        RA = ra; RB = rb; RW = rw; BusW = busw;
        RegWr = regwr; RD = rd; Reserve = reserve; Flush = flush;
    endtask

    task automatic tick();
        @(posedge Clk);
        model_edge();
        #1;
    endtask

    typedef struct {
        logic [4:0]  ra, rb, rw;
        logic [31:0] busw;
        logic        regwr;
        logic [4:0]  rd;
        logic        reserve, flush;
        logic [31:0] ea;
        logic        eva;
        logic [31:0] eb;
        logic        evb, edb;
        logic [5:0]  ecnt;
    } vec_t;

    vec_t tbl [13];

    initial begin
        // Expected values are pre-edge outputs for each record's inputs.
        tbl[0]  = '{5, 7, 0, 32'h0, 0, 5, 1, 0, 32'h0, 1, 32'h0, 1, 0, 0};
        tbl[1]  = '{5, 7, 0, 32'h0, 0, 5, 0, 0, 32'h0, 0, 32'h0, 1, 1, 1};
        tbl[2]  = '{0, 7, 5, 32'hDEADBEEF, 1, 5, 0, 0,
                    32'h0, 1, 32'h0, 1, 1, 1};
        tbl[3]  = '{5, 5, 0, 32'h0, 0, 0, 0, 0,
                    32'hDEADBEEF, 1, 32'hDEADBEEF, 1, 0, 0};
        tbl[4]  = '{5, 5, 7, 32'hA5, 1, 7, 1, 0,
                    32'hDEADBEEF, 1, 32'hDEADBEEF, 1, 0, 0};
        tbl[5]  = '{7, 5, 0, 32'h0, 0, 7, 0, 0,
                    32'hA5, 0, 32'hDEADBEEF, 1, 1, 1};
        tbl[6]  = '{7, 5, 0, 32'hFFFFFFFF, 1, 0, 1, 0,
                    32'hA5, 0, 32'hDEADBEEF, 1, 0, 1};
        tbl[7]  = '{0, 5, 0, 32'h0, 0, 3, 1, 0,
                    32'h0, 1, 32'hDEADBEEF, 1, 0, 1};
        tbl[8]  = '{3, 5, 0, 32'h0, 0, 1, 1, 0,
                    32'h0, 0, 32'hDEADBEEF, 1, 0, 2};
        tbl[9]  = '{1, 5, 0, 32'h0, 0, 2, 1, 0,
                    32'h0, 0, 32'hDEADBEEF, 1, 0, 3};
        tbl[10] = '{2, 5, 0, 32'h0, 0, 4, 1, 1,
                    32'h0, 0, 32'hDEADBEEF, 1, 0, 4};
        tbl[11] = '{4, 5, 0, 32'h0, 0, 4, 0, 0,
                    32'h0, 1, 32'hDEADBEEF, 1, 0, 0};
        tbl[12] = '{7, 3, 0, 32'h0, 0, 7, 0, 0,
                    32'hA5, 1, 32'h0, 1, 0, 0};

        Reset = 1'b1;
        drive(3, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_busa", BusA, 32'h0);
        chk("rst_valida", ValidA, 1);
        chk("rst_validb", ValidB, 1);
        chk("rst_destbusy", DestBusy, 0);
        chk("rst_count", BusyCount, 0);
        Reset = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i].ra, tbl[i].rb, tbl[i].rw, tbl[i].busw,
                  tbl[i].regwr, tbl[i].rd, tbl[i].reserve, tbl[i].flush);
            @(negedge Clk);
            chk($sformatf("tbl%0d_busa", i), BusA, tbl[i].ea);
            chk($sformatf("tbl%0d_valida", i), ValidA, tbl[i].eva);
            chk($sformatf("tbl%0d_busb", i), BusB, tbl[i].eb);
            chk($sformatf("tbl%0d_validb", i), ValidB, tbl[i].evb);
            chk($sformatf("tbl%0d_destbusy", i), DestBusy, tbl[i].edb);
            chk($sformatf("tbl%0d_count", i), BusyCount, 32'(tbl[i].ecnt));
            tick();
        end

        // Async reset mid-run with reg3 written and reserved.
        drive(3, 0, 3, 32'h1234, 1, 3, 1, 0);
        tick();
        drive(3, 0, 0, 0, 0, 3, 0, 0);
        @(negedge Clk);
        chk("pre_rst_busa", BusA, 32'h1234);
        chk("pre_rst_valida", ValidA, 0);
        #2;
        Reset = 1'b1;
        #1;
        chk("async_rst_busa", BusA, 32'h0);
        chk("async_rst_valida", ValidA, 1);
        chk("async_rst_count", BusyCount, 0);
        chk("async_rst_destbusy", DestBusy, 0);
        model_reset();
        @(negedge Clk);
        Reset = 1'b0;
        @(posedge Clk);
        #1;

        // Write to busy reg 9 while reading it in the same cycle.
        drive(0, 0, 0, 0, 0, 9, 1, 0);
        tick();
        drive(9, 9, 9, 32'h55, 1, 0, 0, 0);
        @(negedge Clk);
`ifdef REGFILE_BYPASS_EN
        chk("byp_busa_pre", BusA, 32'h55);
        chk("byp_valida_pre", ValidA, 1);
`else
        chk("byp_busa_pre", BusA, 32'h0);
        chk("byp_valida_pre", ValidA, 0);
`endif
        tick();
        drive(9, 9, 0, 0, 0, 0, 0, 0);
        @(negedge Clk);
        chk("byp_busa_post", BusA, 32'h55);
        chk("byp_valida_post", ValidA, 1);
        chk("byp_count_post", BusyCount, 0);
        tick();

        for (int n = 0; n < 400; n++) begin
            drive(5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
            @(negedge Clk);
            chk("rnd_busa", BusA, exp_read(RA));
            chk("rnd_busb", BusB, exp_read(RB));
            chk("rnd_valida", ValidA, exp_valid(RA));
            chk("rnd_validb", ValidB, exp_valid(RB));
            chk("rnd_destbusy", DestBusy, mbusy[RD]);
            chk("rnd_count", BusyCount, exp_count());
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
